// File: rtl/game_fsm_if.sv
// Round-controller bus: player/bird/dog event inputs plus the state and HUD counters.
// The master drives events and observes the HUD; the slave is the controller itself.
interface game_fsm_if;
    logic        frame_clk;
    logic        start;
    logic        shot_fired;
    logic        bird_hit;
    logic        bird_landed;
    logic        bird_gone;
    logic        dog_start;
    logic        dog_duck;
    logic [2:0]  state;
    logic [1:0]  shots_left;
    logic [3:0]  round;
    logic [3:0]  ducks_hit;
    logic [15:0] score;
    logic        new_round;

    modport master (
        output frame_clk, start, shot_fired, bird_hit, bird_landed, bird_gone,
               dog_start, dog_duck,
        input  state, shots_left, round, ducks_hit, score, new_round
    );

    modport slave (
        input  frame_clk, start, shot_fired, bird_hit, bird_landed, bird_gone,
               dog_start, dog_duck,
        output state, shots_left, round, ducks_hit, score, new_round
    );
endinterface

// File: rtl/game_fsm.sv
// Duck Hunt round-level controller: sequences dog intro, flight, shooting, escape and
// round end, and keeps the shot/round/hit/score counters shown on the HUD.
module game_fsm #(
    parameter int unsigned SHOTS_PER_ROUND = 3,
    parameter int unsigned ROUNDS_PER_GAME = 10,
    parameter int unsigned FLY_TIMEOUT     = 600,
    parameter int unsigned ESCAPE_FRAMES   = 120,
    parameter int unsigned POINTS_PER_HIT  = 500
) (
    input logic       Clk,
    input logic       Reset,
    game_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle     = 3'b000,
        StFly      = 3'b001,
        StFall     = 3'b010,
        StEscape   = 3'b011,
        StLaugh    = 3'b100,
        StDogDuck  = 3'b101,
        StDogStart = 3'b110,
        StGameOver = 3'b111
    } state_e;

    localparam logic [1:0]  ShotsInit  = 2'(SHOTS_PER_ROUND);
    localparam logic [3:0]  LastRound  = 4'(ROUNDS_PER_GAME);
    localparam logic [9:0]  FlyLimit   = 10'(FLY_TIMEOUT);
    localparam logic [9:0]  EscLimit   = 10'(ESCAPE_FRAMES);
    localparam logic [16:0] HitPoints  = 17'(POINTS_PER_HIT);

    state_e      state_q, state_d;
    logic [1:0]  shots_q, shots_d;
    logic [3:0]  round_q, round_d;
    logic [3:0]  ducks_q, ducks_d;
    logic [15:0] score_q, score_d;
    logic        new_round_q, new_round_d;
    logic [9:0]  fly_cnt_q, fly_cnt_d;
    logic [9:0]  esc_cnt_q, esc_cnt_d;
    logic        frame_cur_q, frame_prev_q, frame_tick_q;

    logic        valid_shot;
    logic        fly_timeout;
    logic [16:0] score_sum;

    assign valid_shot  = bus.shot_fired && (shots_q != 2'd0);
    assign fly_timeout = frame_tick_q && ((fly_cnt_q + 10'd1) == FlyLimit);
    assign score_sum   = {1'b0, score_q} + HitPoints;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            shots_q      <= ShotsInit;
            round_q      <= 4'd1;
            ducks_q      <= 4'd0;
            score_q      <= 16'd0;
            new_round_q  <= 1'b0;
            fly_cnt_q    <= 10'd0;
            esc_cnt_q    <= 10'd0;
            frame_cur_q  <= 1'b0;
            frame_prev_q <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shots_q      <= shots_d;
            round_q      <= round_d;
            ducks_q      <= ducks_d;
            score_q      <= score_d;
            new_round_q  <= new_round_d;
            fly_cnt_q    <= fly_cnt_d;
            esc_cnt_q    <= esc_cnt_d;
            frame_cur_q  <= bus.frame_clk;
            frame_prev_q <= frame_cur_q;
            frame_tick_q <= frame_cur_q & ~frame_prev_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        shots_d   = shots_q;
        round_d   = round_q;
        ducks_d   = ducks_q;
        score_d   = score_q;
        fly_cnt_d = fly_cnt_q;
        esc_cnt_d = esc_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StDogStart;
            end
            StDogStart: begin
                if (bus.dog_start) begin
                    state_d   = StFly;
                    fly_cnt_d = 10'd0;
                end
            end
            StFly: begin
                if (frame_tick_q) fly_cnt_d = fly_cnt_q + 10'd1;
                if (valid_shot) shots_d = shots_q - 2'd1;
                // A hit outranks both the last miss and a coincident timeout.
                if (valid_shot && bus.bird_hit) begin
                    state_d = StFall;
                    ducks_d = (ducks_q == 4'd15) ? 4'd15 : ducks_q + 4'd1;
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                end else if ((valid_shot && shots_q == 2'd1) || fly_timeout) begin
                    state_d   = StEscape;
                    esc_cnt_d = 10'd0;
                end
            end
            StFall: begin
                if (bus.bird_landed) state_d = StDogDuck;
            end
            StEscape: begin
                if (bus.bird_gone) begin
                    state_d = StLaugh;
                end else if (frame_tick_q) begin
                    if ((esc_cnt_q + 10'd1) == EscLimit) state_d = StLaugh;
                    else esc_cnt_d = esc_cnt_q + 10'd1;
                end
            end
            StLaugh, StDogDuck: begin
                if (bus.dog_duck) begin
                    if (round_q == LastRound) begin
                        state_d = StGameOver;
                    end else begin
                        state_d   = StFly;
                        round_d   = round_q + 4'd1;
                        shots_d   = ShotsInit;
                        fly_cnt_d = 10'd0;
                    end
                end
            end
            StGameOver: begin
                if (bus.start) begin
                    state_d = StDogStart;
                    score_d = 16'd0;
                    ducks_d = 4'd0;
                    round_d = 4'd1;
                    shots_d = ShotsInit;
                end
            end
            default: state_d = StIdle;
        endcase

        new_round_d = (state_d == StFly) && (state_q != StFly);
    end

    assign bus.state      = state_q;
    assign bus.shots_left = shots_q;
    assign bus.round      = round_q;
    assign bus.ducks_hit  = ducks_q;
    assign bus.score      = score_q;
    assign bus.new_round  = new_round_q;

endmodule
